// File: rtl/reset_request_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_request_sequencer_if
// Request handshake between a reset initiator (software or FSM) and the
// reset_request_sequencer.
//   EN_request  : request strobe, initiator -> sequencer
//   RDY_request : sequencer idle and able to accept, sequencer -> initiator
//   len_in      : assert length in cycles (0 selects the sequencer default)
// Modports: master = initiator side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface reset_request_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             EN_request;
    logic             RDY_request;
    logic [CNT_W-1:0] len_in;

    modport master (
        output EN_request,
        output len_in,
        input  RDY_request
    );

    modport slave (
        input  EN_request,
        input  len_in,
        output RDY_request
    );
endinterface

// File: rtl/reset_request_sequencer.sv
// -----------------------------------------------------------------------------
// reset_request_sequencer
// Drives the reset generator's assert input for a programmable number of
// cycles, then waits for the generated reset (observed at the consumer) to be
// deasserted for SETTLE_CYCLES consecutive cycles before reporting done.
// Flags an error when the generated reset was never seen low during the
// assert window, and counts completed sequences.
//
// Ports:
//   CLK         in   clock, all logic on posedge
//   RST_N       in   synchronous active-low reset
//   req         if   request handshake (EN_request / RDY_request / len_in)
//   ASSERT_OUT  out  registered assert to the reset generator, active high
//   RST_FB      in   generated reset at the consumer, active low
//   busy        out  registered, high in ASSERT, SETTLE and DONE
//   done        out  registered, one-cycle completion pulse
//   err         out  registered, sticky: reset never observed during ASSERT
//   issued_cnt  out  registered count of completed sequences (wraps)
// -----------------------------------------------------------------------------
module reset_request_sequencer #(
    parameter int unsigned ASSERT_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    reset_request_sequencer_if.slave   req,
    output logic                       ASSERT_OUT,
    input  logic                       RST_FB,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [CNT_W-1:0]           issued_cnt
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SETTLE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len_cnt;
    logic [SW-1:0]    settle_cnt;
    logic             seen;

    assign req.RDY_request = (state == IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            len_cnt    <= '0;
            settle_cnt <= '0;
            seen       <= 1'b0;
            ASSERT_OUT <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            issued_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // RDY_request is exactly (state == IDLE), so EN alone
                    // qualifies the accept here.
                    if (req.EN_request) begin
                        len_cnt    <= (req.len_in == '0) ? CNT_W'(ASSERT_CYCLES)
                                                         : req.len_in;
                        seen       <= 1'b0;
                        err        <= 1'b0;
                        settle_cnt <= '0;
                        ASSERT_OUT <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ASSERT;
                    end
                end

                ASSERT: begin
                    seen <= seen | ~RST_FB;
                    // Down-counter holds the remaining assert cycles including
                    // the current one; it never goes below 1 while in ASSERT,
                    // so a full-scale length cannot wrap.
                    if (len_cnt == CNT_W'(1)) begin
                        len_cnt    <= '0;
                        settle_cnt <= '0;
                        ASSERT_OUT <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        len_cnt <= len_cnt - CNT_W'(1);
                    end
                end

                SETTLE: begin
                    if (RST_FB) begin
                        // The edge that sees the SETTLE_CYCLES-th consecutive
                        // high sample is the one that raises done.
                        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                            settle_cnt <= '0;
                            done       <= 1'b1;
                            err        <= ~seen;
                            issued_cnt <= issued_cnt + CNT_W'(1);
                            state      <= DONE;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end else begin
                        settle_cnt <= '0;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_request_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_request_sequencer
// Directed bench for reset_request_sequencer with default parameters
// (ASSERT_CYCLES=4, SETTLE_CYCLES=2, CNT_W=8). Inputs are driven and outputs
// sampled on the falling edge. "idx i" below means the i-th cycle after the
// accept edge.
// RST_FB sources (fb_mode):
//   0: !ASSERT_OUT, same cycle
//   1: !ASSERT_OUT delayed one cycle (low sample lands in first SETTLE cycle)
//   2: tied high (generator never responds)
//   3: scripted per cycle from a low mask
// -----------------------------------------------------------------------------
module tb_reset_request_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       rst_fb;
    logic       ASSERT_OUT;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] issued_cnt;

    logic [1:0] fb_mode = 2'd0;
    logic       fb_low  = 1'b0;
    logic       fb_dly  = 1'b1;

    int total = 0;
    int bad   = 0;

    reset_request_sequencer_if #(.CNT_W(8)) req_if ();

    reset_request_sequencer #(
        .ASSERT_CYCLES (4),
        .SETTLE_CYCLES (2),
        .CNT_W         (8)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req        (req_if),
        .ASSERT_OUT (ASSERT_OUT),
        .RST_FB     (rst_fb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .issued_cnt (issued_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) fb_dly <= !ASSERT_OUT;

    assign rst_fb = (fb_mode == 2'd0) ? !ASSERT_OUT :
                    (fb_mode == 2'd1) ? fb_dly      :
                    (fb_mode == 2'd2) ? 1'b1        : !fb_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to done (bounded). Returns the number of
    // ASSERT_OUT-high cycles, the done index (0 if never seen), err/issued_cnt
    // at the done cycle, busy/RDY/err at idx 1, and RDY the cycle after done.
    task automatic run_seq(
        input  logic [7:0]  len,
        input  logic [31:0] lowmask,
        output int          hi,
        output int          didx,
        output logic        e_done,
        output logic [7:0]  cnt,
        output logic        b1,
        output logic        r1,
        output logic        e1,
        output logic        rdy_after
    );
        req_if.EN_request = 1'b1;
        req_if.len_in     = len;
        @(negedge CLK);
        req_if.EN_request = 1'b0;
        hi     = 0;
        didx   = 0;
        e_done = 1'b0;
        cnt    = '0;
        b1     = busy;
        r1     = req_if.RDY_request;
        e1     = err;
        for (int i = 1; i <= 400; i++) begin
            if (i > 1) @(negedge CLK);
            if (ASSERT_OUT) hi++;
            fb_low = (i < 32) ? lowmask[i] : 1'b0;
            if (done) begin
                didx   = i;
                e_done = err;
                cnt    = issued_cnt;
                break;
            end
        end
        fb_low = 1'b0;
        @(negedge CLK);
        rdy_after = req_if.RDY_request;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int         hi, didx;
        logic       e_done, b1, r1, e1, rdy_after;
        logic [7:0] cnt;
        int         nruns, run_len, dones, rdy_gap, low_gap;
        int         runs [4];

        RST_N             = 1'b0;
        req_if.EN_request = 1'b1;  // must be ignored while in reset
        req_if.len_in     = 8'd0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge CLK);
        chk("rst_assert_out", ASSERT_OUT, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", issued_cnt, 0);
        chk("rst_rdy", req_if.RDY_request, 1);
        req_if.EN_request = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);

        // ---------------- default length ----------------
        fb_mode = 2'd0;
        run_seq(8'd0, 32'h0, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
        chk("def_hi", hi, 4);
        chk("def_done_idx", didx, 7);
        chk("def_err", e_done, 0);
        chk("def_cnt", cnt, 1);
        chk("def_busy_idx1", b1, 1);
        chk("def_rdy_idx1", r1, 0);
        chk("def_rdy_after", rdy_after, 1);

        // ---------------- delayed feedback (lags into SETTLE) ----------------
        fb_mode = 2'd1;
        run_seq(8'd4, 32'h0, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
        chk("dly_hi", hi, 4);
        chk("dly_done_idx", didx, 8);
        chk("dly_err", e_done, 0);
        chk("dly_cnt", cnt, 2);

        // ---------------- held request, len 10 ----------------
        fb_mode = 2'd0;
        req_if.EN_request = 1'b1;
        req_if.len_in     = 8'd10;
        nruns = 0; run_len = 0; dones = 0; rdy_gap = 0; low_gap = 0;
        for (int i = 0; i < 4; i++) runs[i] = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (ASSERT_OUT) begin
                run_len++;
            end else begin
                if (run_len > 0) begin
                    if (nruns < 4) runs[nruns] = run_len;
                    nruns++;
                    run_len = 0;
                end
                if (nruns == 1) low_gap++;
            end
            if (done) dones++;
            if (dones == 1 && !done && req_if.RDY_request) rdy_gap++;
            if (i == 20) req_if.EN_request = 1'b0;
        end
        chk("held_runs", nruns, 2);
        chk("held_run0", runs[0], 10);
        chk("held_run1", runs[1], 10);
        chk("held_dones", dones, 2);
        chk("held_idle_gap", rdy_gap, 1);
        chk("held_low_gap", low_gap, 4);
        chk("held_cnt", issued_cnt, 4);

        // ---------------- missing feedback ----------------
        fb_mode = 2'd2;
        run_seq(8'd3, 32'h0, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
        chk("miss_hi", hi, 3);
        chk("miss_done_idx", didx, 6);
        chk("miss_err", e_done, 1);
        chk("miss_cnt", cnt, 5);
        chk("miss_err_sticky", err, 1);

        fb_mode = 2'd0;
        run_seq(8'd1, 32'h0, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
        chk("clr_err_idx1", e1, 0);
        chk("clr_done_idx", didx, 4);
        chk("clr_err", e_done, 0);
        chk("clr_cnt", cnt, 6);

        // ---------------- settle glitch ----------------
        // Low in both ASSERT cycles and the first SETTLE cycle.
        fb_mode = 2'd3;
        run_seq(8'd2, 32'h0000_000E, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
        chk("glitch_hi", hi, 2);
        chk("glitch_done_idx", didx, 6);
        chk("glitch_err", e_done, 0);
        chk("glitch_cnt", cnt, 7);

        // One good SETTLE high, then a 3-cycle low run, then highs.
        run_seq(8'd2, 32'h0000_0076, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
        chk("run3_done_idx", didx, 9);
        chk("run3_cnt", cnt, 8);

        // ---------------- reset mid-ASSERT ----------------
        fb_mode = 2'd0;
        req_if.EN_request = 1'b1;
        req_if.len_in     = 8'd8;
        @(negedge CLK);
        req_if.EN_request = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("mid_assert_out", ASSERT_OUT, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdy", req_if.RDY_request, 1);
        chk("mid_cnt", issued_cnt, 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (done || ASSERT_OUT) dones++;
        end
        chk("mid_no_activity", dones, 0);

        // ---------------- issued_cnt wrap ----------------
        for (int s = 1; s <= 256; s++) begin
            run_seq(8'd1, 32'h0, hi, didx, e_done, cnt, b1, r1, e1, rdy_after);
            if (s == 255) chk("wrap_255", cnt, 255);
            if (s == 256) chk("wrap_256", cnt, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
